// File: rtl/key_event_scheduler.sv
// PS/2 scancode parser for the Z X C V B game keys.
// Emits make/break events through a small FWFT FIFO and tracks held keys.
module key_event_scheduler #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TO_W           = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] ps2_byte,
  input  logic       ps2_byte_en,
  output logic       event_valid,
  output logic [2:0] event_key,
  output logic       event_make,
  input  logic       event_ready,
  output logic [4:0] key_state,
  output logic       overflow
);

  localparam int PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BRK  = 2'd1;
  localparam logic [1:0] S_EXT  = 2'd2;
  localparam logic [1:0] S_EBRK = 2'd3;

  localparam logic [7:0] B_F0 = 8'hF0;
  localparam logic [7:0] B_E0 = 8'hE0;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]   FULL_N  = CW'(FIFO_DEPTH);

  logic [1:0]      state_q, state_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [4:0]      keys_q, keys_d;
  logic            ovf_q, ovf_d;
  logic [3:0]      head_q, head_d;

  logic [3:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]   rd_q, rd_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [2:0] kcode;
  logic [4:0] koh;
  logic       mapped;
  logic       held;

  logic       push;
  logic       push_make;
  logic [3:0] push_word;
  logic       pop;
  logic       full;
  logic       push_ok;
  logic [CW-1:0] remain;
  logic [PW-1:0] rd_nxt;

  always_comb begin
    kcode = 3'd0;
    koh   = 5'b00000;
    case (ps2_byte)
      8'h1A: begin kcode = 3'd1; koh = 5'b00001; end
      8'h22: begin kcode = 3'd2; koh = 5'b00010; end
      8'h21: begin kcode = 3'd3; koh = 5'b00100; end
      8'h2A: begin kcode = 3'd4; koh = 5'b01000; end
      8'h32: begin kcode = 3'd5; koh = 5'b10000; end
      default: begin kcode = 3'd0; koh = 5'b00000; end
    endcase
  end

  assign mapped = (kcode != 3'd0);
  assign held   = |(keys_q & koh);

  always_comb begin
    state_d   = state_q;
    to_d      = to_q;
    keys_d    = keys_q;
    push      = 1'b0;
    push_make = 1'b0;
    if (ps2_byte_en) begin
      to_d = '0;
      case (state_q)
        S_IDLE: begin
          if (ps2_byte == B_F0) begin
            state_d = S_BRK;
          end else if (ps2_byte == B_E0) begin
            state_d = S_EXT;
          end else if (mapped && !held) begin
            keys_d    = keys_q | koh;
            push      = 1'b1;
            push_make = 1'b1;
          end
        end
        S_BRK: begin
          state_d = S_IDLE;
          if (mapped && held) begin
            keys_d = keys_q & ~koh;
            push   = 1'b1;
          end
        end
        S_EXT: begin
          state_d = (ps2_byte == B_F0) ? S_EBRK : S_IDLE;
        end
        default: begin
          // extended break codes are consumed without touching key state
          state_d = S_IDLE;
        end
      endcase
    end else if (state_q != S_IDLE) begin
      if (to_q == TO_LAST) begin
        state_d = S_IDLE;
        to_d    = '0;
      end else begin
        to_d = to_q + 1'b1;
      end
    end else begin
      to_d = '0;
    end
  end

  assign push_word = {push_make, kcode};
  assign pop       = (cnt_q != '0) && event_ready;
  assign full      = (cnt_q == FULL_N);
  assign push_ok   = push && (!full || pop);
  assign remain    = cnt_q - CW'(pop);
  assign rd_nxt    = rd_q + PW'(pop);

  always_comb begin
    rd_d  = rd_nxt;
    wr_d  = wr_q + PW'(push_ok);
    cnt_d = cnt_q + CW'(push_ok) - CW'(pop);
    ovf_d = ovf_q | (push && full && !pop);
    // head register holds its last value once the FIFO runs dry
    if (cnt_d == '0) begin
      head_d = head_q;
    end else if (remain == '0) begin
      head_d = push_word;
    end else begin
      head_d = mem_q[rd_nxt];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      to_q    <= '0;
      keys_q  <= 5'b00000;
      ovf_q   <= 1'b0;
      head_q  <= 4'b0000;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      to_q    <= to_d;
      keys_q  <= keys_d;
      ovf_q   <= ovf_d;
      head_q  <= head_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && push_ok) begin
      mem_q[wr_q] <= push_word;
    end
  end

  assign event_valid = (cnt_q != '0);
  assign event_key   = head_q[2:0];
  assign event_make  = head_q[3];
  assign key_state   = keys_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_key_event_scheduler.sv
// Directed and random stimulus for key_event_scheduler,
// compared every cycle against a queue-based reference model.
module tb_key_event_scheduler;

  localparam int D = 4;
  localparam int T = 40;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] ps2_byte;
  logic       ps2_byte_en;
  logic       event_valid;
  logic [2:0] event_key;
  logic       event_make;
  logic       event_ready;
  logic [4:0] key_state;
  logic       overflow;

  key_event_scheduler #(
    .FIFO_DEPTH(D),
    .TIMEOUT_CYCLES(T),
    .TO_W(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .ps2_byte(ps2_byte),
    .ps2_byte_en(ps2_byte_en),
    .event_valid(event_valid),
    .event_key(event_key),
    .event_make(event_make),
    .event_ready(event_ready),
    .key_state(key_state),
    .overflow(overflow)
  );

  always #5 clock = ~clock;

  typedef enum {P_IDLE, P_BRK, P_EXT, P_EBRK} pst_t;

  int checks = 0;
  int errors = 0;
  bit rdy = 1'b1;

  logic [3:0] mq[$];
  logic [4:0] m_held;
  logic       m_ovf;
  logic [2:0] m_key;
  logic       m_make;
  pst_t       m_pst;
  int         m_idle;

  function automatic int keymap(input logic [7:0] b);
    case (b)
      8'h1A: return 1;
      8'h22: return 2;
      8'h21: return 3;
      8'h2A: return 4;
      8'h32: return 5;
      default: return 0;
    endcase
  endfunction

  function automatic void model_edge(input bit en, input logic [7:0] b,
                                     input bit r, input bit rst);
    bit pop;
    bit have;
    logic [3:0] ev;
    int k;
    if (rst) begin
      mq.delete();
      m_held = 0; m_ovf = 0; m_key = 0; m_make = 0;
      m_pst = P_IDLE; m_idle = 0;
      return;
    end
    pop  = (mq.size() > 0) && r;
    have = 0;
    ev   = 0;
    k    = keymap(b);
    if (en) begin
      m_idle = 0;
      case (m_pst)
        P_IDLE: begin
          if (b == 8'hF0) m_pst = P_BRK;
          else if (b == 8'hE0) m_pst = P_EXT;
          else if (k != 0 && !m_held[k-1]) begin
            m_held[k-1] = 1'b1;
            have = 1; ev = {1'b1, 3'(k)};
          end
        end
        P_BRK: begin
          m_pst = P_IDLE;
          if (k != 0 && m_held[k-1]) begin
            m_held[k-1] = 1'b0;
            have = 1; ev = {1'b0, 3'(k)};
          end
        end
        P_EXT: m_pst = (b == 8'hF0) ? P_EBRK : P_IDLE;
        default: m_pst = P_IDLE;
      endcase
    end else if (m_pst != P_IDLE) begin
      m_idle++;
      if (m_idle >= T) begin
        m_pst = P_IDLE;
        m_idle = 0;
      end
    end else begin
      m_idle = 0;
    end
    if (pop) void'(mq.pop_front());
    if (have) begin
      if (mq.size() < D) mq.push_back(ev);
      else m_ovf = 1;
    end
    if (mq.size() > 0) begin
      m_key  = mq[0][2:0];
      m_make = mq[0][3];
    end
  endfunction

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit en, input logic [7:0] b, input bit rst);
    reset       = rst;
    ps2_byte_en = en;
    ps2_byte    = b;
    event_ready = rdy;
    @(posedge clock);
    model_edge(en, b, rdy, rst);
    #1;
    check("valid", 8'(event_valid), 8'(mq.size() > 0));
    check("key", 8'(event_key), 8'(m_key));
    check("make", 8'(event_make), 8'(m_make));
    check("key_state", 8'(key_state), 8'(m_held));
    check("overflow", 8'(overflow), 8'(m_ovf));
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  logic [7:0] pick[8];

  initial begin
    pick[0] = 8'h1A; pick[1] = 8'h22; pick[2] = 8'h21; pick[3] = 8'h2A;
    pick[4] = 8'h32; pick[5] = 8'hF0; pick[6] = 8'hE0; pick[7] = 8'h1C;
    m_held = 0; m_ovf = 0; m_key = 0; m_make = 0;
    m_pst = P_IDLE; m_idle = 0;

    // reset state
    step(1'b1, 8'h1A, 1'b1);
    step(1'b1, 8'hF0, 1'b1);
    check("rst_valid", 8'(event_valid), 8'h00);
    check("rst_state", 8'(key_state), 8'h00);

    // press and release Z
    rdy = 1;
    send(8'h1A);
    check("t1_press", 8'(key_state), 8'h01);
    idle(1);
    send(8'hF0); send(8'h1A);
    check("t1_rel", 8'(key_state), 8'h00);
    idle(2);

    // typematic repeats collapse to one press
    rdy = 0;
    send(8'h1A); send(8'h1A); send(8'h1A);
    check("t2_held", 8'(key_state), 8'h01);
    send(8'hF0); send(8'h1A);
    check("t2_cnt", 8'(mq.size()), 8'd2);
    rdy = 1;
    idle(3);

    // extended break must not release Z
    send(8'h1A);
    send(8'hE0); send(8'hF0); send(8'h1A);
    check("t3_held", 8'(key_state), 8'h01);
    send(8'hF0); send(8'h1A);
    idle(2);

    // timeout boundaries
    send(8'h1A);
    send(8'hF0); idle(T - 1); send(8'h1A);
    check("t4_late_brk", 8'(key_state), 8'h00);
    send(8'hF0); idle(T); send(8'h22);
    check("t4_timeout", 8'(key_state), 8'h02);
    idle(2);
    step(1'b0, 8'h00, 1'b1);

    // fill with no consumer, fifth event overflows
    rdy = 0;
    send(8'h1A); send(8'h22); send(8'h21); send(8'h2A); send(8'h32);
    check("t5_ovf", 8'(overflow), 8'h01);
    check("t5_keys", 8'(key_state), 8'h1F);
    rdy = 1;
    idle(5);
    check("t5_empty", 8'(event_valid), 8'h00);

    // full FIFO with simultaneous push and pop
    step(1'b0, 8'h00, 1'b1);
    rdy = 0;
    send(8'h1A); send(8'h22); send(8'h21); send(8'h2A);
    rdy = 1;
    send(8'h32);
    check("t6_no_ovf", 8'(overflow), 8'h00);
    check("t6_cnt", 8'(mq.size()), 8'd4);
    idle(6);

    // reset in the middle of a break sequence
    send(8'hF0);
    step(1'b0, 8'h00, 1'b1);
    check("t6_rst_keys", 8'(key_state), 8'h00);
    send(8'h1A);
    check("t6_after_rst", 8'(key_state), 8'h01);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 499) == 0) begin
        step(1'b0, 8'h00, 1'b1);
      end else if ($urandom_range(0, 59) == 0) begin
        idle(T + 3);
      end else if ($urandom_range(0, 2) == 0) begin
        send(pick[$urandom_range(0, 7)]);
      end else begin
        step(1'b0, 8'($urandom), 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
